// File: rtl/dcsk_tx_sched.sv
// Frame scheduler for the DCSK transmitter: queues {msg, sf} requests, paces one
// frame (on-air chips plus guard gap) at a time and applies pending seed updates.
module dcsk_tx_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GUARD = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_valid,
    input  logic [31:0]                i_req_msg,
    input  logic [1:0]                 i_req_sf,
    output logic                       o_req_ready,
    input  logic [7:0]                 i_seed,
    input  logic                       i_seed_wr,
    output logic [31:0]                o_msg,
    output logic [1:0]                 o_sf,
    output logic [7:0]                 o_seed,
    output logic                       o_load_seed,
    output logic                       o_send,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem_msg [DEPTH];
    logic [1:0]    mem_sf  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nxt;
    logic [12:0]   cnt, frame_last;
    logic          pending, push, pop;

    assign push       = i_req_valid && o_req_ready;
    assign level_nxt  = o_level + LW'(push) - LW'(pop);
    // o_sf already holds the popped entry's SF by the time SEND loads the counter
    assign frame_last = (13'd512 << o_sf) + 13'(GUARD) - 13'd1;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (o_level != '0) begin
                    pop       = 1'b1;
                    state_nxt = pending ? LOAD : SEND;
                end
            end
            LOAD:    state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_msg[wr_ptr] <= i_req_msg;
            mem_sf[wr_ptr]  <= i_req_sf;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_level      <= '0;
            o_req_ready  <= 1'b1;
            o_msg        <= '0;
            o_sf         <= '0;
            o_seed       <= '0;
            pending      <= 1'b0;
            cnt          <= '0;
            o_load_seed  <= 1'b0;
            o_send       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                o_msg  <= mem_msg[rd_ptr];
                o_sf   <= mem_sf[rd_ptr];
            end
            o_level     <= level_nxt;
            o_req_ready <= (level_nxt != LW'(DEPTH));

            // a write coinciding with the LOAD-cycle clear keeps the flag set
            if (i_seed_wr) begin
                o_seed  <= i_seed;
                pending <= 1'b1;
            end else if (state == LOAD) begin
                pending <= 1'b0;
            end

            if (state == SEND)                     cnt <= frame_last;
            else if (state == WAIT && cnt != '0)   cnt <= cnt - 13'd1;

            // strobes are registered from next state so they line up with it
            o_load_seed  <= (state_nxt == LOAD);
            o_send       <= (state_nxt == SEND);
            o_busy       <= (state_nxt != IDLE);
            o_frame_done <= (state == WAIT) && (cnt == 13'd1);
        end
    end
endmodule

// File: tb/tb_dcsk_tx_sched.sv
// Bench for dcsk_tx_sched: table vectors, directed corner sequences and random
// traffic checked every cycle against a timestamp-based reference model.
module tb_dcsk_tx_sched;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GUARD = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
    localparam int unsigned OW    = 47 + LW;

    logic          clk = 1'b0;
    logic          rst_n, req_valid, seed_wr;
    logic          req_ready, load_seed, send, busy, frame_done;
    logic [31:0]   req_msg, msg;
    logic [1:0]    req_sf, sf;
    logic [7:0]    seed_in, seed;
    logic [LW-1:0] level;

    dcsk_tx_sched #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_msg(req_msg),
        .i_req_sf(req_sf), .o_req_ready(req_ready), .i_seed(seed_in), .i_seed_wr(seed_wr),
        .o_msg(msg), .o_sf(sf), .o_seed(seed), .o_load_seed(load_seed), .o_send(send),
        .o_busy(busy), .o_frame_done(frame_done), .o_level(level)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    typedef struct packed { logic [31:0] msg; logic [1:0] sf; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_msg;
    logic [1:0]  m_sf;
    logic [7:0]  m_seed;
    logic        m_pend;
    longint      t_start, t_load, t_send, t_done, t_idle;

    longint     send_log[$], done_log[$], load_log[$];
    logic [7:0] load_seed_log[$];

    typedef struct {
        logic [1:0]  sf;
        logic [31:0] msg;
        int          send_off;
        int          done_off;
        int          idle_off;
    } vec_t;

    function automatic longint frame_len(input logic [1:0] s);
        return (longint'(512) << s) + longint'(GUARD);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_msg = '0; m_sf = '0; m_seed = '0; m_pend = 1'b0;
        t_start = 0; t_idle = 0;
        t_load = -1; t_send = -1; t_done = -1;
    endtask

    // Frame timeline as absolute cycle stamps, fixed at the moment of the pop.
    task automatic model_advance(input logic v, input logic [31:0] m, input logic [1:0] s,
                                 input logic w, input logic [7:0] d, input logic r);
        int   n;
        logic pend_next;
        ent_t e;
        if (!r) begin
            model_reset();
        end else begin
            n = mq.size();
            pend_next = m_pend;
            if (cyc == t_load) pend_next = 1'b0;
            if (w) begin
                m_seed = d;
                pend_next = 1'b1;
            end
            if (cyc >= t_idle && n > 0) begin
                e = mq.pop_front();
                m_msg = e.msg;
                m_sf = e.sf;
                t_start = cyc + 1;
                t_load = m_pend ? cyc + 1 : -1;
                t_send = cyc + 1 + (m_pend ? 1 : 0);
                t_done = t_send + frame_len(e.sf);
                t_idle = t_done + 1;
            end
            if (v && n < DEPTH) begin
                e.msg = m;
                e.sf = s;
                mq.push_back(e);
            end
            m_pend = pend_next;
        end
        cyc++;
    endtask

    function automatic logic [OW-1:0] model_outs();
        return {mq.size() < DEPTH, m_msg, m_sf, m_seed, cyc == t_load, cyc == t_send,
                (cyc >= t_start) && (cyc < t_idle), cyc == t_done, LW'(mq.size())};
    endfunction

    task automatic step(input logic v, input logic [31:0] m, input logic [1:0] s,
                        input logic w, input logic [7:0] d, input logic r);
        logic [OW-1:0] act;
        logic [OW-1:0] exp;
        req_valid = v; req_msg = m; req_sf = s; seed_wr = w; seed_in = d; rst_n = r;
        @(posedge clk);
        #1;
        model_advance(v, m, s, w, d, r);
        act = {req_ready, msg, sf, seed, load_seed, send, busy, frame_done, level};
        exp = model_outs();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL outs cycle %0d: got %h expected %h", cyc, act, exp);
        end
        if (send) send_log.push_back(cyc);
        if (frame_done) done_log.push_back(cyc);
        if (load_seed) begin
            load_log.push_back(cyc);
            load_seed_log.push_back(seed);
        end
    endtask

    task automatic idle_step();
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic push(input logic [31:0] m, input logic [1:0] s);
        step(1'b1, m, s, 1'b0, '0, 1'b1);
    endtask

    task automatic clear_logs();
        send_log.delete(); done_log.delete(); load_log.delete(); load_seed_log.delete();
    endtask

    function automatic int log_size(input int kind);
        case (kind)
            0:       return send_log.size();
            1:       return done_log.size();
            2:       return load_log.size();
            default: return int'(!busy);
        endcase
    endfunction

    task automatic run_until(input int kind, input int n, input int max_cyc, input string name);
        int k = 0;
        while (k < max_cyc && log_size(kind) < n) begin
            idle_step();
            k++;
        end
        total++;
        if (log_size(kind) < n) begin
            bad++;
            $display("FAIL %s timeout: saw %0d events, wanted %0d", name, log_size(kind), n);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_msg"}, msg, 0);
        chk({tag, "_sf"}, sf, 0);
        chk({tag, "_seed"}, seed, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_send"}, send, 0);
        chk({tag, "_load"}, load_seed, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

    initial begin
        vec_t   tbl[4];
        longint t0, s, ta;
        int     acc;

        tbl[0] = '{sf: 2'd0, msg: 32'hDEAD_0000, send_off: 2, done_off: 518,  idle_off: 519};
        tbl[1] = '{sf: 2'd1, msg: 32'h1234_5678, send_off: 2, done_off: 1030, idle_off: 1031};
        tbl[2] = '{sf: 2'd2, msg: 32'hCAFE_F00D, send_off: 2, done_off: 2054, idle_off: 2055};
        tbl[3] = '{sf: 2'd3, msg: 32'h8000_0001, send_off: 2, done_off: 4102, idle_off: 4103};

        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk_reset_values("rst");

        for (int i = 0; i < 4; i++) begin
            clear_logs();
            t0 = cyc;
            push(tbl[i].msg, tbl[i].sf);
            run_until(0, 1, 20, "vec_send");
            chk("vec_msg", msg, tbl[i].msg);
            chk("vec_sf", sf, tbl[i].sf);
            if (send_log.size() > 0) chk("vec_send_off", send_log[0] - t0, tbl[i].send_off);
            run_until(1, 1, 5000, "vec_done");
            if (done_log.size() > 0) chk("vec_done_off", done_log[0] - t0, tbl[i].done_off);
            run_until(3, 1, 5, "vec_idle");
            chk("vec_idle_off", cyc - t0, tbl[i].idle_off);
        end

        clear_logs();
        for (int i = 0; i < 4; i++) push(32'hB000_0000 + i, 2'(i));
        run_until(0, 4, 8000, "b2b_send");
        run_until(1, 4, 5000, "b2b_done");
        if (send_log.size() == 4 && done_log.size() == 4) begin
            chk("b2b_gap01", send_log[1] - send_log[0], 518);
            chk("b2b_gap12", send_log[2] - send_log[1], 1030);
            chk("b2b_gap23", send_log[3] - send_log[2], 2054);
            chk("b2b_last_len", done_log[3] - send_log[3], 4100);
        end
        idle_step();

        clear_logs();
        push(32'hF000_0000, 2'd0);
        run_until(0, 1, 20, "fq_send");
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready) acc++;
            push(32'hF000_0001 + i, 2'd0);
        end
        chk("fq_accepts", acc, 4);
        chk("fq_level_full", level, 4);
        chk("fq_ready_low", req_ready, 0);
        ta = -1;
        for (int k = 0; k < 1000 && ta < 0; k++) begin
            if (req_ready) ta = cyc;
            push(32'hF000_0005, 2'd0);
        end
        chk("fq_stalled_taken_at_send", ta, send_log.size() > 1 ? send_log[1] : -2);
        chk("fq_level_refill", level, 4);
        run_until(1, 6, 6 * 520 + 50, "fq_drain");
        idle_step();

        clear_logs();
        push(32'h5EED_0001, 2'd0);
        run_until(0, 1, 20, "seed_send0");
        repeat (10) idle_step();
        step(1'b0, '0, '0, 1'b1, 8'hA5, 1'b1);
        push(32'h5EED_0002, 2'd1);
        push(32'h5EED_0003, 2'd0);
        run_until(0, 3, 4000, "seed_send");
        run_until(1, 3, 1000, "seed_done");
        chk("seed_load_count", load_log.size(), 1);
        if (load_log.size() >= 1 && send_log.size() >= 2) begin
            chk("seed_load_value", load_seed_log[0], 8'hA5);
            chk("seed_load_to_send", send_log[1] - load_log[0], 1);
        end
        idle_step();

        clear_logs();
        step(1'b0, '0, '0, 1'b1, 8'h11, 1'b1);
        push(32'hACE0_0001, 2'd0);
        run_until(2, 1, 20, "race_load0");
        step(1'b1, 32'hACE0_0002, 2'd0, 1'b1, 8'h3C, 1'b1);
        run_until(0, 2, 1200, "race_send");
        run_until(1, 2, 1000, "race_done");
        chk("race_loads", load_log.size(), 2);
        if (load_log.size() >= 2 && send_log.size() >= 2) begin
            chk("race_seed0", load_seed_log[0], 8'h11);
            chk("race_seed1", load_seed_log[1], 8'h3C);
            chk("race_load_to_send", send_log[1] - load_log[1], 1);
        end
        idle_step();

        clear_logs();
        push(32'h7777_0001, 2'd1);
        push(32'h7777_0002, 2'd0);
        push(32'h7777_0003, 2'd0);
        run_until(0, 1, 20, "mid_send");
        s = (send_log.size() > 0) ? send_log[0] : cyc;
        while (cyc < s + 50) idle_step();
        step(1'b0, '0, '0, 1'b1, 8'h99, 1'b1);
        while (cyc < s + 100) idle_step();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk_reset_values("mid_rst");
        repeat (1200) idle_step();
        chk("mid_rst_no_done", done_log.size(), 0);
        chk("mid_rst_no_resend", send_log.size(), 1);
        clear_logs();
        t0 = cyc;
        push(32'h0FF5_E7ED, 2'd2);
        run_until(0, 1, 20, "fresh_send");
        if (send_log.size() > 0) chk("fresh_send_off", send_log[0] - t0, 2);
        chk("fresh_no_load", load_log.size(), 0);
        run_until(1, 1, 2200, "fresh_done");

        clear_logs();
        for (int i = 0; i < 30000; i++) begin
            step(($urandom % (i < 15000 ? 12 : 900)) == 0, $urandom, 2'($urandom_range(0, 3)),
                 ($urandom % 400) == 0, 8'($urandom), ($urandom % 6000) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcsk_tx_sched.md
# dcsk_tx_sched

Frame scheduler in front of the DCSK transmitter datapath. It queues 32-bit message requests, each with its own spreading-factor ID, and applies any pending chaos-seed update at a frame boundary. It issues one send pulse per frame, then holds the transmitter's message and SF inputs stable for the full on-air frame plus a guard gap. It drives the transmitter's message, send, seed, load-seed and SF inputs directly.

## Interface
Parameters:
- DEPTH, 4: request queue depth; power of two, ≥ 2.
- GUARD, 4: idle chip cycles appended after each frame; range 0..255.

Ports:
- i_clk  in  1  the single clock. One chip per cycle.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_req_valid  in  1  request present.
- i_req_msg  in  32  message payload.
- i_req_sf  in  2  spreading-factor ID for this message.
- o_req_ready  out  1  queue can accept; equals !full.
- i_seed  in  8  new chaos seed.
- i_seed_wr  in  1  capture i_seed and mark the seed pending.
- o_msg  out  32  message to the transmitter; held for the whole frame.
- o_sf  out  2  SF ID to the transmitter; held for the whole frame.
- o_seed  out  8  seed register contents.
- o_load_seed  out  1  one-cycle seed load strobe.
- o_send  out  1  one-cycle frame start strobe.
- o_busy  out  1  state ≠ IDLE.
- o_frame_done  out  1  one-cycle pulse on the last guard cycle.
- o_level  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- Queue: FIFO of {msg, sf}.
  - Push on i_req_valid && o_req_ready.
  - Pop only in IDLE when the queue was non-empty at the start of that cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - A push into an empty queue is not visible to the FSM until the next cycle.
- Frame length N = (512 << sf) + GUARD cycles, i.e. 32 bits × 2 half-symbols × β chips with β = 8 << sf.
  - sf = 0/1/2/3 gives 512/1024/2048/4096 chips plus GUARD.
  - The counter is 13 bits and counts down from N−1.
- Seed handling:
  - i_seed_wr loads seed_reg and sets the pending flag.
  - A write in the same cycle as the LOAD-state clear wins: seed_reg takes the new value and pending stays 1.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into o_msg/o_sf, then go to LOAD if pending, else SEND.
  - LOAD: o_load_seed = 1 for one cycle, o_seed = seed_reg, clear pending, go to SEND.
  - SEND: o_send = 1 for one cycle, load counter = N−1, go to WAIT.
  - WAIT: decrement the counter each cycle. At 0, assert o_frame_done and go to IDLE.
- o_msg and o_sf change only in IDLE on a pop. They are stable from SEND through the end of WAIT.
- New requests and seed writes are accepted in every state. The frame in flight is never altered.
- Reset values:
  - o_req_ready = 1.
  - o_msg = 0, o_sf = 0, o_seed = 0, o_level = 0.
  - o_load_seed, o_send, o_busy and o_frame_done all 0.
  - State IDLE, pending 0, queue empty.
- Reset asserted mid-frame takes effect at the next clock edge. The queue is discarded and pending is cleared; no o_frame_done is emitted.

## Timing
- Request accepted at cycle t into an empty queue while IDLE:
  - pop at t+1, o_send at t+2 (no pending seed);
  - with a pending seed, o_load_seed at t+2 and o_send at t+3.
- o_send at cycle s:
  - WAIT covers s+1 … s+N;
  - o_frame_done at s+N;
  - IDLE at s+N+1;
  - next o_send at s+N+2 at the earliest, or s+N+3 when a seed is pending.
- o_load_seed always precedes o_send by exactly one cycle.
- o_send and o_load_seed are never high together.
- All outputs are registered.

## Test plan
- Single frame, sf=0, GUARD=4, push at cycle 0:
  - o_send at cycle 2 with o_msg = the pushed value;
  - o_frame_done at 518; o_busy low at 519.
- Back-to-back, four pushes with sf = 0, 1, 2, 3 → o_send spacings of 518, 1030 and 2054 cycles. The last frame ends 4100 cycles after its o_send. o_msg/o_sf never change inside WAIT.
- Full queue: DEPTH=4, five valid cycles while a frame is in flight → o_req_ready drops after the fourth accept and the fifth is stalled. The first pop raises o_req_ready and the stalled request is taken, with o_level tracking throughout.
- Seed update: i_seed_wr with 0xA5 during WAIT → at the next frame o_load_seed pulses with o_seed = 0xA5, followed one cycle later by o_send. The following frame has no o_load_seed.
- Seed race: i_seed_wr with 0x3C in the LOAD cycle → pending stays 1. o_seed = 0x3C is loaded before the next frame's o_send.
- Reset mid-frame: i_rst_n low for one cycle at s+100 → next cycle shows all reset values, o_level = 0 and no o_frame_done. A fresh push then gives o_send 2 cycles after its accept.
